// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Drives the PLL reset, waits for a stable lock and sequences the
//            system reset. Also counts lock losses and lock timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt
);

  localparam int C_MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int C_MAX    = (C_MAX_AB > SETTLE_CYCLES) ? C_MAX_AB : SETTLE_CYCLES;
  localparam int CNT_W    = $clog2(C_MAX);

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             lock_loss_q, lock_loss_d;
  logic [7:0]             timeout_q, timeout_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    lock_loss_d = lock_loss_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d = ST_PLL_RESET;
          if (timeout_q != 8'hFF) timeout_d = timeout_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!locked_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt_q == C_SETTLE_LAST) state_d = ST_RUN;
      end
      default: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          if (lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;
        end else if (soft_rst) begin
          state_d = ST_SETTLE;
        end
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    pll_rst_d = (state_d == ST_PLL_RESET);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      sync_q      <= '0;
      lock_loss_q <= 8'd0;
      timeout_q   <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      lock_loss_q <= lock_loss_d;
      timeout_q   <= timeout_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_q;
  assign timeout_cnt   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Directed self-checking bench for pll_reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [7:0] timeout_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .SETTLE_CYCLES (8),
    .SYNC_STAGES   (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_rst     (soft_rst),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_pll, input logic e_sys, input logic e_rdy);
    chk({tag, ".pll_rst"}, {31'd0, pll_rst}, {31'd0, e_pll});
    chk({tag, ".sys_rst"}, {31'd0, sys_rst}, {31'd0, e_sys});
    chk({tag, ".ready"},   {31'd0, ready},   {31'd0, e_rdy});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk_outs("reset", 1'b1, 1'b1, 1'b0);
    chk("reset.lock_loss", {24'd0, lock_loss_cnt}, 32'd0);
    chk("reset.timeout", {24'd0, timeout_cnt}, 32'd0);
    tick(2);
    rst = 1'b0;

    // Power-up: pll_rst high for 4 edges, lock raised 10 cycles after release
    tick(3);
    chk_outs("pwr.e3", 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_outs("pwr.e4", 1'b0, 1'b1, 1'b0);
    tick(6);
    pll_locked = 1'b1;
    tick(10);
    chk_outs("pwr.k9", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("pwr.k10", 1'b0, 1'b0, 1'b1);
    chk("pwr.lock_loss", {24'd0, lock_loss_cnt}, 32'd0);
    chk("pwr.timeout", {24'd0, timeout_cnt}, 32'd0);

    // Lock loss in RUN: 3-cycle drop
    tick(3);
    pll_locked = 1'b0;
    tick(2);
    chk_outs("loss.m1", 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_outs("loss.m2", 1'b0, 1'b1, 1'b0);
    chk("loss.cnt", {24'd0, lock_loss_cnt}, 32'd1);
    pll_locked = 1'b1;
    tick(10);
    chk_outs("loss.r9", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("loss.r10", 1'b0, 1'b0, 1'b1);
    chk("loss.timeout", {24'd0, timeout_cnt}, 32'd0);

    // soft_rst A: one-cycle pulse gives 8 cycles of sys_rst
    tick(2);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk_outs("soft.n", 1'b0, 1'b1, 1'b0);
    tick(7);
    chk_outs("soft.n7", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("soft.n8", 1'b0, 1'b0, 1'b1);
    chk("soft.lock_loss", {24'd0, lock_loss_cnt}, 32'd1);

    // Settle abort: lock drops 5 cycles into SETTLE
    tick(1);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(5);
    pll_locked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_outs("abort.hold", 1'b0, 1'b1, 1'b0);
    end
    chk("abort.lock_loss", {24'd0, lock_loss_cnt}, 32'd1);
    pll_locked = 1'b1;
    tick(10);
    chk_outs("abort.r9", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("abort.r10", 1'b0, 1'b0, 1'b1);

    // soft_rst B: soft_rst on the cycle locked_s falls, lock loss wins
    tick(2);
    pll_locked = 1'b0;
    tick(2);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk_outs("coll.m2", 1'b0, 1'b1, 1'b0);
    chk("coll.lock_loss", {24'd0, lock_loss_cnt}, 32'd2);

    // Lock timeout: WAIT_LOCK entered on this edge, re-pulse after 20 cycles
    tick(19);
    chk_outs("to.w19", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("to.w20", 1'b1, 1'b1, 1'b0);
    chk("to.cnt1", {24'd0, timeout_cnt}, 32'd1);
    tick(3);
    chk_outs("to.p3", 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_outs("to.p4", 1'b0, 1'b1, 1'b0);
    tick(20);
    chk("to.cnt2", {24'd0, timeout_cnt}, 32'd2);
    for (int i = 3; i <= 257; i++) begin
      tick(23);
      chk_outs("to.gap", 1'b0, 1'b1, 1'b0);
      tick(1);
      chk_outs("to.pulse", 1'b1, 1'b1, 1'b0);
      chk("to.cnt", {24'd0, timeout_cnt}, (i > 255) ? 32'd255 : i);
    end
    chk("to.lock_loss", {24'd0, lock_loss_cnt}, 32'd2);

    // Mid-SETTLE async reset
    pll_locked = 1'b1;
    tick(4);
    chk_outs("mid.wait", 1'b0, 1'b1, 1'b0);
    tick(4);
    chk_outs("mid.settle", 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_outs("mid.settle_rst", 1'b1, 1'b1, 1'b0);
    chk("mid.settle_rst.timeout", {24'd0, timeout_cnt}, 32'd0);
    chk("mid.settle_rst.lock_loss", {24'd0, lock_loss_cnt}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(12);
    chk_outs("relock.e12", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("relock.e13", 1'b0, 1'b0, 1'b1);

    // Lock-loss counter saturation
    for (int i = 1; i <= 256; i++) begin
      pll_locked = 1'b0;
      tick(3);
      chk("sat.sys_rst", {31'd0, sys_rst}, 32'd1);
      pll_locked = 1'b1;
      tick(11);
      chk("sat.ready", {31'd0, ready}, 32'd1);
      chk("sat.cnt", {24'd0, lock_loss_cnt}, (i > 255) ? 32'd255 : i);
    end
    chk("sat.timeout", {24'd0, timeout_cnt}, 32'd0);

    // Mid-RUN async reset
    #2 rst = 1'b1;
    #1;
    chk_outs("mid.run_rst", 1'b1, 1'b1, 1'b0);
    chk("mid.run_rst.lock_loss", {24'd0, lock_loss_cnt}, 32'd0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
